// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART TX burst scheduler.
package uart_tx_sched_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    GUARD = 2'd2
  } sched_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [ID_W-1:0]  i_last_grant,
  input  logic [N_REQ-1:0] i_req,
  output logic [ID_W-1:0]  o_winner,
  output logic             o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_sel;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    o_winner = i_last_grant;
    o_any    = |i_req;
    w_sum    = '0;
    w_sel    = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      w_sum = {1'b0, i_last_grant} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      w_sel = w_sum[ID_W-1:0];
      if (i_req[w_sel]) o_winner = w_sel;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin burst scheduler sharing one UART TX core among N_REQ byte sources,
// with a baud-timed guard gap between bursts and a stall timeout on each grant.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned GUARD_BITS = 2,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_tick,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    grant_active
);

  localparam int unsigned BW = cnt_w(MAX_BURST);
  localparam int unsigned SW = cnt_w(TIMEOUT);
  localparam int unsigned GW = cnt_w(GUARD_BITS);

  sched_state_t    r_state;
  logic [ID_W-1:0] r_grant_id;
  logic [ID_W-1:0] r_last_grant;
  logic [BW-1:0]   r_burst_cnt;
  logic [SW-1:0]   r_stall_cnt;
  logic [GW-1:0]   r_guard_cnt;

  logic [ID_W-1:0]   w_winner;
  logic              w_any;
  logic [DATA_W-1:0] w_lane [N_REQ];
  logic              w_sel_valid;
  logic              w_xfer;
  logic              w_burst_end;
  logic              w_timeout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_last_grant (r_last_grant),
    .i_req        (req_valid),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign w_lane[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_xfer      = (r_state == XFER) && w_sel_valid && tx_ready;
  assign w_burst_end = w_xfer &&
                       (req_last[r_grant_id] || (r_burst_cnt == BW'(MAX_BURST - 1)));
  // Release fires on the tick that would bring the stall count to TIMEOUT.
  assign w_timeout   = (r_state == XFER) && !w_xfer && baud_tick &&
                       (r_stall_cnt == SW'(TIMEOUT - 1));

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (r_state == XFER) begin
      tx_valid              = w_sel_valid;
      tx_data               = w_lane[r_grant_id];
      req_ready[r_grant_id] = tx_ready;
    end
  end

  assign grant_active = (r_state == XFER);
  assign grant_id     = r_grant_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_burst_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_guard_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= XFER;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_burst_cnt  <= '0;
            r_stall_cnt  <= '0;
          end
        end
        XFER: begin
          if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_stall_cnt <= '0;
          end else if (baud_tick) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
          if (w_burst_end || w_timeout) begin
            if (GUARD_BITS == 0) begin
              r_state <= IDLE;
            end else begin
              r_state     <= GUARD;
              r_guard_cnt <= GW'(GUARD_BITS);
            end
          end
        end
        GUARD: begin
          if (baud_tick) begin
            r_guard_cnt <= r_guard_cnt - 1'b1;
            if (r_guard_cnt == GW'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, directed corner cases, random scoreboard.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int GB = 2;
  localparam int TO = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_tick = 1'b0;
  logic          tx_ready = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*DW-1:0] req_data = '0;

  logic [N-1:0]  req_ready, req_ready_b;
  logic          tx_valid, tx_valid_b;
  logic [DW-1:0] tx_data, tx_data_b;
  logic [IW-1:0] grant_id, grant_id_b;
  logic          grant_active, grant_active_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .GUARD_BITS(GB), .TIMEOUT(TO), .ID_W(IW)
  ) u_dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .grant_active(grant_active)
  );

  uart_tx_sched #(
    .N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .GUARD_BITS(0), .TIMEOUT(TO), .ID_W(IW)
  ) u_dut_g0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready),
    .grant_id(grant_id_b), .grant_active(grant_active_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0; baud_tick = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Round-robin rule: first set bit after last, wrapping around.
  function automatic int rr_expect(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    logic [N-1:0]    rl;
    logic            rdy;
    logic            tick;
    logic            etv;
    logic [DW-1:0]   etd;
    logic [N-1:0]    err;
    logic            ega;
    logic [IW-1:0]   egid;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] rv, input logic [N*DW-1:0] rd,
                              input logic [N-1:0] rl, input logic rdy, input logic tick,
                              input logic etv, input logic [DW-1:0] etd,
                              input logic [N-1:0] err, input logic ega, input logic [IW-1:0] egid);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rl = rl; v.rdy = rdy; v.tick = tick;
    v.etv = etv; v.etd = etd; v.err = err; v.ega = ega; v.egid = egid;
    return v;
  endfunction

  vec_t tbl [10];

  logic [7:0] q_d [N][$];
  bit         q_l [N][$];
  logic [7:0] rx [$];
  int         seq_a [$];
  int         seq_b [$];
  int         lows [3];

  initial begin
    int cnt, stall_ticks, k, wcnt, gap_b, mg, burst, gap_ticks, remaining, exp_w;
    bit got, tv_bad, early_drop, seen_ga, prev_a, prev_b, first_grant, last_was_last;
    logic [N-1:0] prev_rv, exp_rr;

    // ---- Table: two 2-byte bursts from requesters 0 and 2 with a 2-tick guard
    tbl[0] = mk(4'b0101, 32'h00B0_00A0, 4'b0000, 1, 0,  0, 8'h00, 4'b0000, 0, 0);
    tbl[1] = mk(4'b0101, 32'h00B0_00A0, 4'b0000, 1, 0,  1, 8'hA0, 4'b0001, 1, 0);
    tbl[2] = mk(4'b0101, 32'h00B0_00A1, 4'b0001, 1, 0,  1, 8'hA1, 4'b0001, 1, 0);
    tbl[3] = mk(4'b0100, 32'h00B0_0000, 4'b0000, 1, 1,  0, 8'h00, 4'b0000, 0, 0);
    tbl[4] = mk(4'b0100, 32'h00B0_0000, 4'b0000, 1, 0,  0, 8'h00, 4'b0000, 0, 0);
    tbl[5] = mk(4'b0100, 32'h00B0_0000, 4'b0000, 1, 1,  0, 8'h00, 4'b0000, 0, 0);
    tbl[6] = mk(4'b0100, 32'h00B0_0000, 4'b0000, 1, 0,  0, 8'h00, 4'b0000, 0, 0);
    tbl[7] = mk(4'b0100, 32'h00B0_0000, 4'b0000, 1, 0,  1, 8'hB0, 4'b0100, 1, 2);
    tbl[8] = mk(4'b0100, 32'h00B1_0000, 4'b0100, 1, 0,  1, 8'hB1, 4'b0100, 1, 2);
    tbl[9] = mk(4'b0000, 32'h0000_0000, 4'b0000, 1, 1,  0, 8'h00, 4'b0000, 0, 2);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = tbl[i].rv; req_data = tbl[i].rd; req_last = tbl[i].rl;
      tx_ready = tbl[i].rdy; baud_tick = tbl[i].tick;
      #1;
      chk($sformatf("t1_row%0d_tx_valid", i), tx_valid, tbl[i].etv);
      chk($sformatf("t1_row%0d_tx_data", i), tx_data, tbl[i].etd);
      chk($sformatf("t1_row%0d_req_ready", i), req_ready, tbl[i].err);
      chk($sformatf("t1_row%0d_grant_active", i), grant_active, tbl[i].ega);
      chk($sformatf("t1_row%0d_grant_id", i), grant_id, tbl[i].egid);
    end

    // ---- Max burst: req 1 never sets last, req 3 waiting
    do_reset();
    cnt = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      req_valid = 4'b1010; req_last = '0; tx_ready = 1'b1; baud_tick = (c % 4 == 0);
      req_data = '0; req_data[1*DW +: DW] = 8'(8'h40 + cnt); req_data[3*DW +: DW] = 8'hEE;
      #1;
      if (grant_active && grant_id == 2'd3) got = 1;
      else if (tx_valid && tx_ready) begin
        chk("t2_burst_byte", {grant_id, tx_data}, {2'd1, 8'(8'h40 + cnt)});
        cnt++;
      end
    end
    chk("t2_req3_granted", got, 1);
    chk("t2_burst_len", cnt, MB);

    // ---- Stall timeout: req 0 drops valid right after its grant
    do_reset();
    stall_ticks = 0; got = 0; tv_bad = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? 4'b0011 : 4'b0010; req_last = '0; req_data = '0;
      tx_ready = 1'b1; baud_tick = (c % 2 == 1);
      #1;
      if (grant_active && grant_id == 2'd0) begin
        if (tx_valid) tv_bad = 1;
        if (baud_tick) stall_ticks++;
      end else if (grant_active && grant_id == 2'd1) got = 1;
    end
    chk("t3_timeout_ticks", stall_ticks, TO);
    chk("t3_tx_valid_during_stall", tv_bad, 0);
    chk("t3_next_grant", got, 1);

    // ---- Back-pressure: 10 ticks then 25 ticks of tx_ready low inside one burst
    do_reset();
    lows[0] = 10; lows[1] = 25; lows[2] = 0;
    k = 0; wcnt = 0; early_drop = 0; seen_ga = 0;
    rx.delete();
    for (int c = 0; c < 400 && k < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b0100; req_data = '0; req_data[2*DW +: DW] = 8'(8'hC0 + k);
      req_last = (k == 2) ? 4'b0100 : 4'b0000;
      tx_ready = (wcnt >= lows[k]); baud_tick = 1'b1;
      #1;
      if (grant_active) seen_ga = 1;
      else if (seen_ga) early_drop = 1;
      if (tx_valid && tx_ready) begin
        rx.push_back(tx_data); k++; wcnt = 0;
      end else if (grant_active) wcnt++;
    end
    chk("t4_byte_count", rx.size(), 3);
    for (int i = 0; i < rx.size(); i++) chk($sformatf("t4_byte%0d", i), rx[i], 8'(8'hC0 + i));
    chk("t4_grant_held", early_drop, 0);

    // ---- All requesting, 1-byte bursts; guard=2 and guard=0 instances
    do_reset();
    seq_a.delete(); seq_b.delete();
    prev_a = 0; prev_b = 0; gap_b = 0;
    for (int c = 0; c < 400 && (seq_a.size() < 5 || seq_b.size() < 5); c++) begin
      @(negedge clk);
      req_valid = '1; req_last = '1; req_data = 32'h3322_1100; tx_ready = 1'b1;
      baud_tick = (c % 3 == 0);
      #1;
      if (grant_active && !prev_a) seq_a.push_back(int'(grant_id));
      if (grant_active_b && !prev_b) begin
        if (seq_b.size() > 0) chk("t5_g0_idle_gap", gap_b, 1);
        seq_b.push_back(int'(grant_id_b));
        gap_b = 0;
      end
      if (!grant_active_b) gap_b++;
      prev_a = grant_active; prev_b = grant_active_b;
    end
    chk("t5_grants_a", seq_a.size() >= 5, 1);
    chk("t5_grants_b", seq_b.size() >= 5, 1);
    for (int i = 0; i < 5 && i < seq_a.size(); i++) chk($sformatf("t5_a_seq%0d", i), seq_a[i], i % 4);
    for (int i = 0; i < 5 && i < seq_b.size(); i++) chk($sformatf("t5_b_seq%0d", i), seq_b[i], i % 4);

    // ---- Reset pulsed mid-burst
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_last = '0; req_data = 32'h00D0_0000; tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t6_in_xfer", {grant_active, grant_id}, {1'b1, 2'd2});
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_grant_active", grant_active, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = '1;
    @(negedge clk);
    #1;
    chk("t6_first_grant", {grant_active, grant_id}, {1'b1, 2'd0});

    // ---- Random traffic against a transaction-level scoreboard
    do_reset();
    for (int i = 0; i < N; i++) begin
      q_d[i].delete(); q_l[i].delete();
      for (int j = 0; j < 20; j++) begin
        q_d[i].push_back(8'(i * 32 + j));
        q_l[i].push_back((j == 19) || (i != 1 && $urandom_range(0, 3) == 0));
      end
    end
    mg = N - 1; burst = 0; gap_ticks = 0; first_grant = 1; last_was_last = 0;
    prev_a = 0; prev_rv = '0;
    for (int c = 0; c < 8000; c++) begin
      remaining = 0;
      for (int i = 0; i < N; i++) remaining += q_d[i].size();
      if (remaining == 0) break;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (q_d[i].size() != 0) && ($urandom_range(0, 9) != 0);
        req_data[i*DW +: DW] = (q_d[i].size() != 0) ? q_d[i][0] : 8'h00;
        req_last[i] = (q_d[i].size() != 0) ? q_l[i][0] : 1'b0;
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      baud_tick = (c % 4 == 0);
      #1;
      if (grant_active && !prev_a) begin
        exp_w = rr_expect(prev_rv, mg);
        chk("rnd_winner", grant_id, exp_w);
        if (!first_grant) chk("rnd_guard_ticks", gap_ticks >= GB, 1);
        first_grant = 0; mg = exp_w; burst = 0;
      end
      if (!grant_active && prev_a) begin
        chk("rnd_burst_end", (burst == MB) || last_was_last, 1);
        gap_ticks = 0;
      end
      if (!grant_active) begin
        if (baud_tick) gap_ticks++;
        chk("rnd_idle_outputs", {tx_valid, req_ready}, 0);
      end else begin
        exp_rr = '0;
        exp_rr[mg] = tx_ready;
        chk("rnd_tx_valid", tx_valid, req_valid[mg]);
        chk("rnd_req_ready", req_ready, exp_rr);
        if (req_valid[mg] && tx_ready) begin
          chk("rnd_tx_data", tx_data, q_d[mg][0]);
          last_was_last = q_l[mg][0];
          void'(q_d[mg].pop_front());
          void'(q_l[mg].pop_front());
          burst++;
          if (burst > MB) chk("rnd_burst_limit", burst, MB);
        end
      end
      prev_a = grant_active; prev_rv = req_valid;
    end
    remaining = 0;
    for (int i = 0; i < N; i++) remaining += q_d[i].size();
    chk("rnd_all_drained", remaining, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
